// File: rtl/pc_sequencer.sv
// Program-counter sequencer. It holds the PC, forms pc+4 with a two-level
// carry-lookahead adder, and decodes the jump and branch opcodes. It then
// selects the absolute target or the fall-through address as the next PC.

// 32-bit two-level carry-lookahead adder.
// Level one is eight 4-bit groups that produce group generate/propagate terms.
// Level two is a lookahead unit that forms every group carry-in directly from
// those terms. No carry-out is produced, so the sum wraps modulo 2^32.
module pc_cla_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);

  logic [31:0] bit_g;
  logic [31:0] bit_p;
  logic [7:0]  grp_g;
  logic [7:0]  grp_p;
  logic [7:0]  grp_c;

  assign bit_g = a & b;
  assign bit_p = a ^ b;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_group
      logic [3:0] gg;
      logic [3:0] pp;
      logic [3:0] cc;

      assign gg = bit_g[gi*4 +: 4];
      assign pp = bit_p[gi*4 +: 4];

      // Group generate/propagate, exported to the second lookahead level.
      assign grp_g[gi] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) |
                         (pp[3] & pp[2] & pp[1] & gg[0]);
      assign grp_p[gi] = &pp;

      // In-group carries, all expanded from the group carry-in.
      assign cc[0] = grp_c[gi];
      assign cc[1] = gg[0] | (pp[0] & grp_c[gi]);
      assign cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & grp_c[gi]);
      assign cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) |
                     (pp[2] & pp[1] & pp[0] & grp_c[gi]);

      assign sum[gi*4 +: 4] = pp ^ cc;
    end
  endgenerate

  // Second-level lookahead: each group carry is a sum of products of the
  // group G/P terms and cin. These are flat terms and do not ripple from
  // group to group.
  always_comb begin
    grp_c    = '0;
    grp_c[0] = cin;
    for (int k = 1; k < 8; k++) begin
      logic c_acc;
      logic prod;
      c_acc = 1'b0;
      for (int j = 0; j < k; j++) begin
        prod = grp_g[j];
        for (int m = j + 1; m < k; m++) begin
          prod = prod & grp_p[m];
        end
        c_acc = c_acc | prod;
      end
      prod = cin;
      for (int m = 0; m < k; m++) begin
        prod = prod & grp_p[m];
      end
      grp_c[k] = c_acc | prod;
    end
  end

endmodule

// Parameterized-width equality comparator built from per-bit XNORs.
module pc_eq_cmp #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq
);

  logic [WIDTH-1:0] bit_eq;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign bit_eq[gi] = ~(a[gi] ^ b[gi]);
    end
  endgenerate

  assign eq = &bit_eq;

endmodule

// Parameterized-width AND gate.
module pc_and_gate #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in,
  output logic             y
);

  assign y = &in;

endmodule

// Top level. The decoded function field is exposed as func_code.
module pc_sequencer #(
  parameter logic [31:0] INIT_ADDRESS = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [1:0]  jump_type,
  input  logic        cond_src,
  input  logic [31:0] alu_out,
  input  logic [31:0] fpsr,
  input  logic [31:0] jump_reg,
  input  logic [31:0] iar,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_four,
  output logic [5:0]  op_code,
  output logic [5:0]  func_code
);

  // The four jump opcodes, packed so a generate loop can slice one per comparator.
  localparam logic [23:0] JUMP_OPS = {6'h13, 6'h12, 6'h03, 6'h02};

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] imm16;
  logic [31:0] imm26;
  logic [31:0] jump_pc;
  logic [3:0]  jump_hit;
  logic        is_jump;
  logic        is_branch;
  logic        branch_val;
  logic        take;
  logic        unused_bits;

  // Only bit 0 of the ALU result and of the FP status is a branch condition.
  assign unused_bits = &{1'b0, alu_out[31:1], fpsr[31:1]};

  assign pc      = pc_reg;
  assign op_code = instr[31:26];

  // Odd opcodes use a 5-bit function field; bit 5 reads as zero.
  assign func_code = op_code[0] ? {1'b0, instr[4:0]} : instr[5:0];

  assign imm16 = {{16{instr[15]}}, instr[15:0]};
  assign imm26 = {{6{instr[25]}}, instr[25:0]};

  pc_cla_adder32 u_inc (
    .a   (pc_reg),
    .b   (32'd4),
    .cin (1'b0),
    .sum (pc_plus_four)
  );

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_jump_cmp
      pc_eq_cmp #(.WIDTH(6)) u_cmp (
        .a  (op_code),
        .b  (JUMP_OPS[gi*6 +: 6]),
        .eq (jump_hit[gi])
      );
    end
  endgenerate

  assign is_jump = |jump_hit;

  // Branch opcodes 0x04-0x07: the top three bits are clear and bit 2 is set.
  pc_and_gate #(.WIDTH(4)) u_branch_dec (
    .in ({~op_code[5], ~op_code[4], ~op_code[3], op_code[2]}),
    .y  (is_branch)
  );

  assign branch_val = cond_src ? alu_out[0] : fpsr[0];
  assign take       = is_jump | (is_branch & branch_val);

  // Absolute target select; no target is PC-relative.
  always_comb begin
    jump_pc = jump_reg;
    case (jump_type)
      2'b00:   jump_pc = jump_reg;
      2'b01:   jump_pc = imm16;
      2'b10:   jump_pc = imm26;
      default: jump_pc = iar;
    endcase
  end

  // Either take the selected target or fall through to pc+4.
  always_comb begin
    pc_next = pc_plus_four;
    if (take) begin
      pc_next = jump_pc;
    end
  end

  // The PC advances on every edge; a synchronous reset overrides any jump.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= INIT_ADDRESS;
    end else begin
      pc_reg <= pc_next;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed sequences with literal expectations, then
// randomized traffic checked every cycle against a behavioural next-PC model.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic [1:0]  jump_type;
  logic        cond_src;
  logic [31:0] alu_out;
  logic [31:0] fpsr;
  logic [31:0] jump_reg;
  logic [31:0] iar;
  logic [31:0] pc;
  logic [31:0] pc_plus_four;
  logic [5:0]  op_code;
  logic [5:0]  func_code;

  int errors = 0;
  int checks = 0;
  bit started = 0;
  logic [31:0] model_pc;

  pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .jump_type    (jump_type),
    .cond_src     (cond_src),
    .alu_out      (alu_out),
    .fpsr         (fpsr),
    .jump_reg     (jump_reg),
    .iar          (iar),
    .pc           (pc),
    .pc_plus_four (pc_plus_four),
    .op_code      (op_code),
    .func_code    (func_code)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference next PC from the rules: the jump opcode set, the branch opcode
  // range, the condition source and the absolute target select.
  function automatic logic [31:0] model_next(input logic [31:0] cur);
    int unsigned op;
    bit jmp;
    bit br;
    bit cond;
    logic [31:0] target;
    op   = int'(instr[31:26]);
    jmp  = (op == 2) || (op == 3) || (op == 18) || (op == 19);
    br   = (op >= 4) && (op <= 7);
    cond = cond_src ? alu_out[0] : fpsr[0];
    case (jump_type)
      2'd0:    target = jump_reg;
      2'd1:    target = 32'(int'($signed(instr[15:0])));
      2'd2:    target = 32'(int'($signed(instr[25:0])));
      default: target = iar;
    endcase
    if (jmp || (br && cond)) return target;
    return 32'((64'(cur) + 64'd4) % 64'h1_0000_0000);
  endfunction

  always @(posedge clk) begin
    model_pc <= reset ? 32'h0 : model_next(model_pc);
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      logic [5:0] exp_func;
      exp_func = instr[26] ? {1'b0, instr[4:0]} : instr[5:0];
      checks++;
      if (pc !== model_pc) begin
        errors++;
        $display("FAIL model_pc t=%0t actual=%h required=%h", $time, pc, model_pc);
      end
      checks++;
      if (pc_plus_four !== model_pc + 32'd4) begin
        errors++;
        $display("FAIL model_ppf t=%0t actual=%h required=%h", $time, pc_plus_four, model_pc + 32'd4);
      end
      checks++;
      if (op_code !== instr[31:26]) begin
        errors++;
        $display("FAIL model_op t=%0t actual=%h required=%h", $time, op_code, instr[31:26]);
      end
      checks++;
      if (func_code !== exp_func) begin
        errors++;
        $display("FAIL model_func t=%0t actual=%h required=%h", $time, func_code, exp_func);
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [1:0] jt, input logic cs,
                       input logic [31:0] alu, input logic [31:0] fp,
                       input logic [31:0] jr, input logic [31:0] ir);
    instr = i; jump_type = jt; cond_src = cs; alu_out = alu;
    fpsr = fp; jump_reg = jr; iar = ir;
  endtask

  initial begin
    logic [31:0] r;
    logic [5:0]  op;
    logic [5:0]  interesting [8];
    interesting = '{6'h02, 6'h03, 6'h12, 6'h13, 6'h04, 6'h05, 6'h06, 6'h07};

    reset = 1;
    drive(32'h0, 2'b10, 1'b1, 32'h1, 32'h1, 32'hDEAD_BEEF, 32'h0BAD_0000);
    tick();
    tick();
    started = 1;
    check_lit("reset_pc", pc, 32'h0);
    check_lit("reset_ppf", pc_plus_four, 32'h4);

    // Fall-through sequence 0, 4, 8, 0xC.
    reset = 0;
    tick(); check_lit("nop_pc4", pc, 32'h4);
    tick(); check_lit("nop_pc8", pc, 32'h8);
    tick(); check_lit("nop_pcC", pc, 32'hC);
    check_lit("nop_ppf10", pc_plus_four, 32'h10);

    // imm26 jump with a negative target, then fall-through.
    drive({6'h02, 26'h3FF_FFF0}, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick(); check_lit("imm26_jump", pc, 32'hFFFF_FFF0);
    drive(32'h0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick(); check_lit("imm26_nop", pc, 32'hFFFF_FFF4);

    // Branch on the ALU bit: taken, then not taken.
    drive({6'h04, 10'h0, 16'h0100}, 2'b01, 1'b1, 32'h1, 32'h0, 32'h0, 32'h0);
    tick(); check_lit("br_alu_taken", pc, 32'h0000_0100);
    alu_out = 32'h0;
    tick(); check_lit("br_alu_not", pc, 32'h0000_0104);

    // Branch on the FP status to iar, then a register jump.
    drive({6'h05, 26'h0}, 2'b11, 1'b0, 32'h0, 32'h1, 32'h0, 32'h0000_2000);
    tick(); check_lit("br_fpsr_iar", pc, 32'h0000_2000);
    drive({6'h13, 26'h0}, 2'b00, 1'b0, 32'h0, 32'h0, 32'h40, 32'h0);
    tick(); check_lit("jump_reg", pc, 32'h0000_0040);

    // Wrap from the top of the address space.
    drive({6'h02, 26'h0}, 2'b00, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0);
    tick(); check_lit("jump_top", pc, 32'hFFFF_FFFC);
    check_lit("ppf_wrap", pc_plus_four, 32'h0);
    drive(32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick(); check_lit("pc_wrap", pc, 32'h0);

    // Function-field decode.
    instr = 32'h0400_003F; #1;
    check_lit("func_odd", {26'h0, func_code}, 32'h1F);
    instr = 32'h0000_003F; #1;
    check_lit("func_even", {26'h0, func_code}, 32'h3F);

    // Reset during a taken jump, then release with the jump still present.
    drive({6'h02, 26'h0}, 2'b00, 1'b0, 32'h0, 32'h0, 32'h1234, 32'h0);
    reset = 1;
    tick(); check_lit("reset_in_jump", pc, 32'h0);
    reset = 0;
    tick(); check_lit("post_reset_jump", pc, 32'h1234);
    instr = 32'h0;
    tick(); check_lit("post_reset_nop", pc, 32'h1238);

    // Randomized traffic checked by the per-cycle compare process.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom();
      if ($urandom_range(0, 1) == 0) op = interesting[$urandom_range(0, 7)];
      else op = 6'($urandom_range(0, 63));
      drive({op, r[25:0]}, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom(), $urandom(), $urandom(), $urandom());
      reset = ($urandom_range(0, 49) == 0);
      tick();
    end

    started = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
